// File: rtl/acc_unit_p.sv
// Accumulator unit with falling-edge state updates: single-cycle ALU ops plus multi-cycle shifts.
// Define ACC_MUL_EN to build the shift-add multiplier (opcode 01100); otherwise that opcode is illegal.
module acc_unit_p #(
  parameter  int WIDTH = 32,
  localparam int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             op_valid,
  input  logic [4:0]       op_code,
  output logic             op_ready,
  input  logic [WIDTH-1:0] operand_r,
  input  logic [7:0]       mem_byte,
  input  logic [SHW-1:0]   shamt,
  output logic [WIDTH-1:0] acc_out,
  output logic             z,
  output logic             n,
  output logic             c,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int CW = SHW + 1;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_LOAD  = 5'b00001;
  localparam logic [4:0] OP_ADD   = 5'b00010;
  localparam logic [4:0] OP_SUB   = 5'b00011;
  localparam logic [4:0] OP_XOR   = 5'b00100;
  localparam logic [4:0] OP_AND   = 5'b00101;
  localparam logic [4:0] OP_CLR   = 5'b00110;
  localparam logic [4:0] OP_INC   = 5'b00111;
  localparam logic [4:0] OP_DEC   = 5'b01000;
  localparam logic [4:0] OP_SHL   = 5'b01001;
  localparam logic [4:0] OP_SHR   = 5'b01010;
  localparam logic [4:0] OP_LOADB = 5'b01011;
`ifdef ACC_MUL_EN
  localparam logic [4:0] OP_MUL   = 5'b01100;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT
`ifdef ACC_MUL_EN
    , S_MUL
`endif
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_c;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_left;
  logic [CW-1:0]    r_cnt;

  logic [WIDTH:0]   w_add;
  logic [WIDTH:0]   w_sub;

  assign w_add = {1'b0, r_acc} + {1'b0, operand_r};
  assign w_sub = {1'b0, r_acc} - {1'b0, operand_r};

`ifdef ACC_MUL_EN
  // Product register: upper half accumulates, lower half holds the remaining multiplier bits.
  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_prod_nxt;

  assign w_mul_sum  = {1'b0, r_prod[2*WIDTH-1:WIDTH]} + (r_prod[0] ? {1'b0, r_mcand} : '0);
  assign w_prod_nxt = {w_mul_sum, r_prod[WIDTH-1:1]};
`endif

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_c     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      r_left  <= 1'b0;
      r_cnt   <= '0;
`ifdef ACC_MUL_EN
      r_prod  <= '0;
      r_mcand <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        S_IDLE: if (op_valid) begin
          r_done <= 1'b1;
          case (op_code)
            OP_NOP:   ;
            OP_LOAD:  begin r_acc <= operand_r;           r_c <= 1'b0;         end
            OP_ADD:   begin r_acc <= w_add[WIDTH-1:0];    r_c <= w_add[WIDTH]; end
            OP_SUB:   begin r_acc <= w_sub[WIDTH-1:0];    r_c <= w_sub[WIDTH]; end
            OP_XOR:   begin r_acc <= r_acc ^ operand_r;   r_c <= 1'b0;         end
            OP_AND:   begin r_acc <= r_acc & operand_r;   r_c <= 1'b0;         end
            OP_CLR:   begin r_acc <= '0;                  r_c <= 1'b0;         end
            OP_INC:   begin r_acc <= r_acc + 1'b1;        r_c <= &r_acc;       end
            OP_DEC:   begin r_acc <= r_acc - 1'b1;        r_c <= ~|r_acc;      end
            OP_LOADB: r_acc <= {r_acc[WIDTH-1:8], mem_byte};
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                r_c <= 1'b0;
              end else begin
                r_done  <= 1'b0;
                r_busy  <= 1'b1;
                r_state <= S_SHIFT;
                r_left  <= (op_code == OP_SHL);
                r_cnt   <= {1'b0, shamt};
              end
            end
`ifdef ACC_MUL_EN
            OP_MUL: begin
              r_done  <= 1'b0;
              r_busy  <= 1'b1;
              r_state <= S_MUL;
              r_prod  <= {{WIDTH{1'b0}}, r_acc};
              r_mcand <= operand_r;
              r_cnt   <= CW'(WIDTH);
            end
`endif
            default: r_err <= 1'b1;
          endcase
        end
        S_SHIFT: begin
          if (r_left) begin
            r_acc <= {r_acc[WIDTH-2:0], 1'b0};
            r_c   <= r_acc[WIDTH-1];
          end else begin
            r_acc <= {1'b0, r_acc[WIDTH-1:1]};
            r_c   <= r_acc[0];
          end
          r_cnt <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`ifdef ACC_MUL_EN
        S_MUL: begin
          r_prod <= w_prod_nxt;
          r_cnt  <= r_cnt - 1'b1;
          if (r_cnt == CW'(1)) begin
            r_acc   <= w_prod_nxt[WIDTH-1:0];
            r_c     <= |w_prod_nxt[2*WIDTH-1:WIDTH];
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign acc_out  = r_acc;
  assign z        = (r_acc == '0);
  assign n        = r_acc[WIDTH-1];
  assign c        = r_c;
  assign busy     = r_busy;
  assign op_ready = ~r_busy;
  assign done     = r_done;
  assign err      = r_err;

endmodule

// File: tb/tb_acc_unit_p.sv
// Scoreboard bench for acc_unit_p: driver pushes model results, monitor checks on every done pulse.
module tb_acc_unit_p;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          op_valid = 1'b0;
  logic [4:0]    op_code = '0;
  logic          op_ready;
  logic [W-1:0]  operand_r = '0;
  logic [7:0]    mem_byte = '0;
  logic [4:0]    shamt = '0;
  logic [W-1:0]  acc_out;
  logic          z, n, c, busy, done, err;

  acc_unit_p #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .op_valid(op_valid), .op_code(op_code), .op_ready(op_ready),
    .operand_r(operand_r), .mem_byte(mem_byte), .shamt(shamt), .acc_out(acc_out),
    .z(z), .n(n), .c(c), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] acc;
    logic         c;
    logic         err;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           vectors = 0;
  int           miscompares = 0;
  int           cyc = 0;
  logic [W-1:0] m_acc = '0;
  logic         m_c = 1'b0;

  always @(negedge clk) cyc++;

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(posedge clk) begin
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL spurious_done: done=1 with no outstanding op (cycle %0d)", cyc);
      end else begin
        e = sb.pop_front();
        chk("acc",        acc_out, e.acc);
        chk("c",          W'(c),   W'(e.c));
        chk("err",        W'(err), W'(e.err));
        chk("z",          W'(z),   W'(e.acc == '0));
        chk("n",          W'(n),   W'(e.acc[W-1]));
        chk("done_cycle", W'(cyc), W'(e.cyc));
      end
    end
  end

  // Issue one opcode once the unit is ready; garbage is driven while busy to show it is ignored.
  task automatic issue(input logic [4:0] op, input logic [W-1:0] r,
                       input logic [7:0] b, input logic [4:0] sh);
    int           g;
    int           lat;
    logic [63:0]  p;
    logic [W-1:0] a;
    logic         cc, er;
    exp_t         e;
    g = 0;
    @(posedge clk);
    while (!op_ready && g < 200) begin
      op_valid  = 1'b1;
      op_code   = 5'($urandom);
      operand_r = $urandom;
      mem_byte  = 8'($urandom);
      shamt     = 5'($urandom);
      g++;
      @(posedge clk);
    end
    if (!op_ready) begin
      vectors++;
      miscompares++;
      $display("FAIL ready_timeout: op_ready=0 expected 1 after %0d cycles", g);
      return;
    end
    op_valid = 1'b1; op_code = op; operand_r = r; mem_byte = b; shamt = sh;
    a = m_acc; cc = m_c; er = 1'b0; lat = 0;
    case (op)
      5'd0:  ;
      5'd1:  begin a = r; cc = 1'b0; end
      5'd2:  begin p = {32'b0, a} + {32'b0, r}; a = p[31:0]; cc = p[32]; end
      5'd3:  begin cc = (a < r); a = a - r; end
      5'd4:  begin a = a ^ r; cc = 1'b0; end
      5'd5:  begin a = a & r; cc = 1'b0; end
      5'd6:  begin a = '0; cc = 1'b0; end
      5'd7:  begin cc = (a == 32'hFFFF_FFFF); a = a + 1; end
      5'd8:  begin cc = (a == 0); a = a - 1; end
      5'd9:  if (sh == 0) cc = 1'b0;
             else begin cc = a[W - int'(sh)]; a = a << sh; lat = int'(sh); end
      5'd10: if (sh == 0) cc = 1'b0;
             else begin cc = a[int'(sh) - 1]; a = a >> sh; lat = int'(sh); end
      5'd11: a[7:0] = b;
`ifdef ACC_MUL_EN
      5'd12: begin p = {32'b0, a} * {32'b0, r}; a = p[31:0]; cc = |p[63:32]; lat = W; end
`endif
      default: er = 1'b1;
    endcase
    m_acc = a; m_c = cc;
    e.acc = a; e.c = cc; e.err = er; e.cyc = cyc + 1 + lat;
    sb.push_back(e);
  endtask

  task automatic idle(input int k);
    repeat (k) begin
      @(posedge clk);
      op_valid = 1'b0;
      operand_r = $urandom;
      shamt = 5'($urandom);
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (sb.size() != 0 && g < 100) begin
      @(posedge clk);
      op_valid = 1'b0;
      g++;
    end
    if (sb.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL drain_timeout: %0d ops outstanding expected 0", sb.size());
    end
  endtask

  task automatic chk_reset_state();
    chk("rst_acc",   acc_out,       '0);
    chk("rst_c",     W'(c),         '0);
    chk("rst_busy",  W'(busy),      '0);
    chk("rst_done",  W'(done),      '0);
    chk("rst_err",   W'(err),       '0);
    chk("rst_ready", W'(op_ready),  W'(1));
    chk("rst_z",     W'(z),         W'(1));
  endtask

  initial begin
    logic [4:0]   op;
    logic [W-1:0] r;
    repeat (3) @(posedge clk);
    #1 chk_reset_state();
    @(posedge clk); #2 rst = 1'b0;

    issue(5'd1, 32'h0000_00FF, 8'h00, 5'd0);
    issue(5'd6, 32'h0, 8'h00, 5'd0);
    issue(5'd1, 32'hFFFF_FFFF, 8'h00, 5'd0);
    issue(5'd2, 32'h1, 8'h00, 5'd0);
    issue(5'd8, 32'h0, 8'h00, 5'd0);
    issue(5'd1, 32'h8000_0001, 8'h00, 5'd0);
    issue(5'd9, 32'h0, 8'h00, 5'd3);
    issue(5'd10, 32'h0, 8'h00, 5'd0);
    issue(5'd1, 32'h0001_0000, 8'h00, 5'd0);
    issue(5'd12, 32'h0002_0000, 8'h00, 5'd0);
    issue(5'd1, 32'h7, 8'h00, 5'd0);
    issue(5'd12, 32'h6, 8'h00, 5'd0);
    issue(5'd1, 32'h1234_5678, 8'h00, 5'd0);
    issue(5'd11, 32'h0, 8'hAB, 5'd0);
    issue(5'd31, 32'hDEAD_BEEF, 8'h00, 5'd0);
    issue(5'd7, 32'h0, 8'h00, 5'd0);
    issue(5'd0, 32'h0, 8'h00, 5'd0);
    drain();

    // Abort a multi-cycle op partway through with an asynchronous reset.
    issue(5'd1, 32'h0000_0123, 8'h00, 5'd0);
`ifdef ACC_MUL_EN
    issue(5'd12, 32'h0000_0456, 8'h00, 5'd0);
`else
    issue(5'd9, 32'h0, 8'h00, 5'd20);
`endif
    idle(10);
    #2 rst = 1'b1;
    #1 chk_reset_state();
    sb.delete();
    m_acc = '0; m_c = 1'b0;
    @(posedge clk); #2 rst = 1'b0;
    issue(5'd1, 32'hCAFE_0001, 8'h00, 5'd0);
    drain();

    for (int i = 0; i < 250; i++) begin
      op = ($urandom_range(0, 9) == 0) ? 5'($urandom) : 5'($urandom_range(0, 12));
      case ($urandom_range(0, 5))
        0:       r = '0;
        1:       r = 32'hFFFF_FFFF;
        2:       r = 32'($urandom_range(0, 15));
        default: r = $urandom;
      endcase
      issue(op, r, 8'($urandom), ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom));
      if ($urandom_range(0, 4) == 0) idle($urandom_range(1, 3));
    end
    drain();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/acc_unit_p.md
Name: acc_unit_p

Overview:
- Parametrised next-generation accumulator for the image-processor datapath.
- Holds one WIDTH-bit accumulator register and executes opcodes issued by the control unit over a valid/ready handshake.
- Adds multi-cycle shift-by-N and shift-add multiply, a registered carry flag, a busy/done handshake, and an illegal-opcode flag.
- The zero flag drives branch decisions in the controller.

Parameters:
- WIDTH, 32, accumulator and operand width; must be >= 8.
- SHW, $clog2(WIDTH), shift-amount width; derived localparam, not overridable.

Ports:
- clk  input  1  system clock; all state updates on the falling edge.
- rst  input  1  asynchronous active-high reset.
- op_valid  input  1  opcode present this cycle.
- op_code  input  5  operation select (encoding below).
- op_ready  output  1  unit can accept an opcode; equals !busy.
- operand_r  input  WIDTH  R operand; sampled at acceptance.
- mem_byte  input  8  memory byte for LOADB; sampled at acceptance.
- shamt  input  SHW  shift amount for SHL/SHR; sampled at acceptance.
- acc_out  output  WIDTH  accumulator value.
- z  output  1  acc_out == 0 (combinational).
- n  output  1  acc_out[WIDTH-1] (combinational).
- c  output  1  registered carry/borrow/overflow flag.
- busy  output  1  multi-cycle operation in progress.
- done  output  1  one-cycle pulse when an operation completes.
- err  output  1  one-cycle pulse when an illegal opcode is accepted.

Behaviour:
- Reset (async, rst=1): acc=0, c=0, busy=0, done=0, err=0, FSM=IDLE. Asserting rst mid-operation aborts it with no done pulse.
- Acceptance: on a falling edge with op_valid && op_ready. Opcodes presented while busy are ignored, not queued.
- Opcode encoding; single-cycle ops complete at the accept edge:
  - 00000 NOP: acc unchanged; done still pulses.
  - 00001 LOAD: acc=R; c=0.
  - 00010 ADD: acc=acc+R mod 2^WIDTH; c=carry out.
  - 00011 SUB: acc=acc-R; c=borrow (1 when acc<R unsigned).
  - 00100 XOR: acc=acc^R; c=0.
  - 00101 AND: acc=acc&R; c=0.
  - 00110 CLR: acc=0; c=0.
  - 00111 INC: acc=acc+1; c=1 on wrap all-ones -> 0.
  - 01000 DEC: acc=acc-1; c=1 on wrap 0 -> all-ones.
  - 01011 LOADB: acc[7:0]=mem_byte; acc[WIDTH-1:8] preserved; c unchanged.
  - 01001 SHL / 01010 SHR: logical shift by shamt, multi-cycle.
  - 01100 MUL: multi-cycle (see below).
  - All other codes: illegal. acc and c unchanged; err and done pulse at the accept edge.
- done timing: done is registered. It is high for exactly the one cycle after the completing edge. busy falls on that same completing edge.
- FSM states: IDLE, SHIFT, MUL.
- SHIFT:
  - Entered on SHL/SHR with shamt != 0; busy=1.
  - One bit shifted per edge; c = last bit shifted out.
  - Completes after exactly shamt edges, then returns to IDLE.
  - shamt=0 completes as a single-cycle op with acc unchanged and c=0.
- MUL:
  - Entered on MUL; busy=1.
  - Unsigned shift-add over a 2*WIDTH-bit product using the latched operand_r.
  - Takes exactly WIDTH edges after acceptance.
  - Result: acc = product[WIDTH-1:0]; c=1 if product[2*WIDTH-1:WIDTH] != 0.
- During SHIFT/MUL, acc_out may show intermediate values. Consumers wait for done.
- Changes to operand_r, mem_byte or shamt after acceptance have no effect.

Optional Feature:
- Macro: ACC_MUL_EN.
- Defined: MUL (01100) is implemented as above and the MUL state exists.
- Undefined: 01100 is an illegal opcode (err+done pulse, no change). No multiplier datapath or MUL state is synthesised.

Test Plan (WIDTH=32):
- Reset then LOAD R=0x0000_00FF -> acc=0xFF, z=0, c=0, done pulses one cycle after the accept edge. Then CLR -> acc=0, z=1.
- LOAD 0xFFFF_FFFF, ADD R=1 -> acc=0, z=1, c=1. Then DEC -> acc=0xFFFF_FFFF, c=1, n=1.
- LOAD 0x8000_0001, SHL shamt=3 -> busy for 3 edges, op_valid ignored meanwhile; final acc=0x0000_0008, c=0 (last bit out is bit 29). SHR shamt=0 -> single-cycle, acc unchanged.
- With ACC_MUL_EN: LOAD 0x0001_0000, MUL R=0x0002_0000 -> busy 32 edges, acc=0, c=1. LOAD 7, MUL R=6 -> acc=42, c=0.
- LOAD 0x1234_5678, LOADB mem_byte=0xAB -> acc=0x1234_56AB. Then op_code=11111 -> err and done pulse, acc unchanged.
- Assert rst mid-MUL (edge 10) -> acc=0, busy=0, no done. The next LOAD is accepted normally.
